// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU issue side, the result buffer and register-file writeback.
// The slave modport is the buffer; the master modport is whatever drives ALU results and accepts writeback.
interface alu_result_buffer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [ADDR_W-1:0] in_dest;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic [CNT_W-1:0]  count;
  logic              flag_zero;
  logic              flag_ones;
  logic              drop_err;

  modport master (
    output in_valid, in_result, in_dest, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_addr, count, flag_zero, flag_ones, drop_err
  );

  modport slave (
    input  in_valid, in_result, in_dest, wb_ready,
    output in_ready, wb_valid, wb_data, wb_addr, count, flag_zero, flag_ones, drop_err
  );
endinterface

// File: rtl/alu_result_buffer.sv
// FIFO between ALU results and register-file writeback; tracks zero/all-ones of the last
// written-back value and a sticky overflow flag.
module alu_result_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_buffer_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              flag_zero_q, flag_zero_d;
  logic              flag_ones_q, flag_ones_d;
  logic              drop_err_q, drop_err_d;
  logic              push, pop, not_empty;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;

  assign not_empty = (count_q != '0);
  // Full refuses pushes even when a pop happens the same cycle: no bypass path.
  assign push      = bus.in_valid && (count_q != FULL);
  assign pop       = not_empty && bus.wb_ready;
  assign head_data = not_empty ? data_mem_q[rd_ptr_q] : '0;
  assign head_addr = not_empty ? addr_mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    flag_zero_d = flag_zero_q;
    flag_ones_d = flag_ones_q;
    drop_err_d  = drop_err_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      flag_zero_d = (head_data == '0);
      flag_ones_d = (head_data == '1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.in_valid && !push) drop_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flag_zero_q <= 1'b0;
      flag_ones_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flag_zero_q <= flag_zero_d;
      flag_ones_q <= flag_ones_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the count is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= bus.in_result;
      addr_mem_q[wr_ptr_q] <= bus.in_dest;
    end
  end

  assign bus.in_ready  = (count_q != FULL);
  assign bus.wb_valid  = not_empty;
  assign bus.wb_data   = head_data;
  assign bus.wb_addr   = head_addr;
  assign bus.count     = count_q;
  assign bus.flag_zero = flag_zero_q;
  assign bus.flag_ones = flag_ones_q;
  assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed checks of the ALU result buffer: reset, single transfer, fill/overflow,
// concurrent push/pop across wrap, flags, stall hold and asynchronous reset mid-operation.
module tb_alu_result_buffer;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_result_buffer_if #(.DATA_W(8), .ADDR_W(3), .DEPTH(4)) bus ();

  alu_result_buffer #(.DATA_W(8), .ADDR_W(3), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_dest   = '0;
    bus.wb_ready  = 1'b0;
    #2;
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_wb_data", 32'(bus.wb_data), 32'h00);
    chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("rst_flags", 32'({bus.flag_zero, bus.flag_ones}), 32'd0);
    chk("rst_drop_err", 32'(bus.drop_err), 32'd0);
    step();
    step();
    rst = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Single transfer
    bus.in_valid = 1'b1; bus.in_result = 8'hA5; bus.in_dest = 3'd3; bus.wb_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("single_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("single_wb_data", 32'(bus.wb_data), 32'hA5);
    chk("single_wb_addr", 32'(bus.wb_addr), 32'd3);
    chk("single_count1", 32'(bus.count), 32'd1);
    step();
    chk("single_count0", 32'(bus.count), 32'd0);
    chk("single_empty_valid", 32'(bus.wb_valid), 32'd0);
    chk("single_empty_data", 32'(bus.wb_data), 32'h00);
    chk("single_flag_zero", 32'(bus.flag_zero), 32'd0);
    chk("single_flag_ones", 32'(bus.flag_ones), 32'd0);

    // Fill to full, then overflow
    bus.wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_result = 8'(i); bus.in_dest = 3'(i);
      step();
    end
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_drop_before", 32'(bus.drop_err), 32'd0);
    bus.in_result = 8'h05; bus.in_dest = 3'd5;
    step();
    bus.in_valid = 1'b0;
    chk("ovf_drop_err", 32'(bus.drop_err), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd4);
    chk("ovf_head", 32'(bus.wb_data), 32'h01);
    bus.wb_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(bus.wb_data), 32'(i));
      chk("drain_addr", 32'(bus.wb_addr), 32'(i));
      step();
    end
    chk("drain_empty", 32'(bus.wb_valid), 32'd0);
    chk("drain_count", 32'(bus.count), 32'd0);
    chk("drain_drop_sticky", 32'(bus.drop_err), 32'd1);
    step();
    chk("pop_empty_count", 32'(bus.count), 32'd0);

    // Concurrent push and pop at count=2, through pointer wrap
    bus.wb_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_result = 8'h10; bus.in_dest = 3'd1;
    step();
    bus.in_result = 8'h11; bus.in_dest = 3'd2;
    step();
    chk("conc_count_start", 32'(bus.count), 32'd2);
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_result = 8'(8'h33 + i); bus.in_dest = 3'(i);
      chk("conc_count", 32'(bus.count), 32'd2);
      chk("conc_head", 32'(bus.wb_data), (i < 2) ? 32'(8'h10 + i) : 32'(8'h33 + i - 2));
      step();
    end
    bus.in_valid = 1'b0;
    chk("conc_tail0", 32'(bus.wb_data), 32'h3B);
    chk("conc_tail0_addr", 32'(bus.wb_addr), 32'd0);
    step();
    chk("conc_tail1", 32'(bus.wb_data), 32'h3C);
    chk("conc_tail1_addr", 32'(bus.wb_addr), 32'd1);
    step();
    chk("conc_count_end", 32'(bus.count), 32'd0);

    // Flags
    bus.wb_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_result = 8'h00; bus.in_dest = 3'd0;
    step();
    bus.in_result = 8'hFF; bus.in_dest = 3'd7;
    step();
    bus.in_valid = 1'b0;
    chk("flag_hold_zero", 32'(bus.flag_zero), 32'd0);
    bus.wb_ready = 1'b1;
    step();
    chk("flag00_zero", 32'(bus.flag_zero), 32'd1);
    chk("flag00_ones", 32'(bus.flag_ones), 32'd0);
    step();
    chk("flagFF_zero", 32'(bus.flag_zero), 32'd0);
    chk("flagFF_ones", 32'(bus.flag_ones), 32'd1);
    step();
    chk("flag_held_ones", 32'(bus.flag_ones), 32'd1);

    // Stall with 0x7E at head
    bus.wb_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_result = 8'h7E; bus.in_dest = 3'd5;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus.wb_valid), 32'd1);
      chk("stall_data", 32'(bus.wb_data), 32'h7E);
      chk("stall_addr", 32'(bus.wb_addr), 32'd5);
      step();
    end

    // Reset mid-operation at count=3
    bus.in_valid = 1'b1; bus.in_result = 8'h81; bus.in_dest = 3'd1;
    step();
    bus.in_result = 8'h82; bus.in_dest = 3'd2;
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.wb_valid), 32'd0);
    chk("async_rst_count", 32'(bus.count), 32'd0);
    chk("async_rst_drop", 32'(bus.drop_err), 32'd0);
    chk("async_rst_data", 32'(bus.wb_data), 32'h00);
    chk("async_rst_flags", 32'({bus.flag_zero, bus.flag_ones}), 32'd0);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_result = 8'h5A; bus.in_dest = 3'd6;
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_count", 32'(bus.count), 32'd1);
    chk("post_rst_data", 32'(bus.wb_data), 32'h5A);
    chk("post_rst_addr", 32'(bus.wb_addr), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
